// File: rtl/config_chain_loader_if.sv
// Word handshake between a bitstream source and config_chain_loader.
// The source drives data/valid; the loader answers with ready.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Scan-chain front end: takes bitstream words and shifts them LSB-first into the
// fabric configuration chain, with a clear pulse ahead of every load.
module config_chain_loader #(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  config_chain_loader_if.slave   word_if,
  output logic                   chain_data,
  output logic                   chain_enable,
  output logic                   chain_nreset,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int BC_W = $clog2(CHAIN_LENGTH + 1);
  localparam int WB_W = $clog2(WORD_WIDTH);
  localparam int CC_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]            state_q,     state_d;
  logic [CC_W-1:0]       clr_cnt_q,   clr_cnt_d;
  logic [BC_W-1:0]       bit_count_q, bit_count_d;
  logic [WB_W-1:0]       word_bit_q,  word_bit_d;
  logic [WORD_WIDTH-1:0] shreg_q,     shreg_d;
  logic                  overrun_q,   overrun_d;

  // Next-state and datapath update for the load sequence.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    bit_count_d = bit_count_q;
    word_bit_d  = word_bit_q;
    shreg_d     = shreg_q;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CC_W'(CLEAR_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == {CC_W{1'b0}}) begin
          state_d     = ST_WAIT;
          bit_count_d = {BC_W{1'b0}};
        end else begin
          clr_cnt_d = clr_cnt_q - CC_W'(1);
        end
      end
      ST_WAIT: begin
        if (word_if.word_valid) begin
          state_d    = ST_SHIFT;
          shreg_d    = word_if.word_data;
          word_bit_d = {WB_W{1'b0}};
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SHIFT: begin
        shreg_d     = {1'b0, shreg_q[WORD_WIDTH-1:1]};
        bit_count_d = bit_count_q + BC_W'(1);
        // word_bit is parked at zero on exit so it never wraps inside a load.
        if (bit_count_q == BC_W'(CHAIN_LENGTH - 1)) begin
          state_d    = ST_DONE;
          word_bit_d = {WB_W{1'b0}};
        end else if (word_bit_q == WB_W'(WORD_WIDTH - 1)) begin
          state_d    = ST_WAIT;
          word_bit_d = {WB_W{1'b0}};
        end else begin
          word_bit_d = word_bit_q + WB_W'(1);
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CC_W'(CLEAR_CYCLES - 1);
          overrun_d = 1'b0;
        end else if (word_if.word_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= {CC_W{1'b0}};
      bit_count_q <= {BC_W{1'b0}};
      word_bit_q  <= {WB_W{1'b0}};
      shreg_q     <= {WORD_WIDTH{1'b0}};
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      bit_count_q <= bit_count_d;
      word_bit_q  <= word_bit_d;
      shreg_q     <= shreg_d;
      overrun_q   <= overrun_d;
    end
  end

  // Strobes decode from registered state only, so no input reaches an output.
  assign word_if.word_ready = (state_q == ST_WAIT);
  assign chain_enable       = (state_q == ST_SHIFT);
  assign chain_data         = (state_q == ST_SHIFT) & shreg_q[0];
  assign chain_nreset       = (state_q != ST_CLEAR);
  assign busy               = (state_q == ST_CLEAR) | (state_q == ST_WAIT) | (state_q == ST_SHIFT);
  assign done               = (state_q == ST_DONE);
  assign overrun            = overrun_q;

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Front-end loader for the fabric configuration scan chain: accepts bitstream words on a valid/ready interface and serialises them LSB-first onto the chain's serial config input.
- Generates the chain's enable and active-low clear strobes.
- Sits directly upstream of the first tile on the chain. The serial output feeds that tile's config_in; the enable and clear outputs fan out to every tile's config_enable and config_nreset.
- Asserts done once exactly CHAIN_LENGTH bits have been shifted.

Parameters:
- WORD_WIDTH, 32, width of incoming bitstream words (>=2).
- CHAIN_LENGTH, 1024, total number of configuration bits in the chain (>=1).
- CLEAR_CYCLES, 4, number of cycles chain_nreset is held low at the start of each load (>=1).

Ports:
- clock  input  1  fabric configuration clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; acted on only in IDLE or DONE.
- word_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word_data this cycle.
- chain_data  output  1  serial bit to the chain's config_in.
- chain_enable  output  1  chain shift enable (config_enable).
- chain_nreset  output  1  active-low chain clear (config_nreset).
- busy  output  1  load in progress (CLEAR, WAIT_WORD, SHIFT).
- done  output  1  full chain loaded; held until the next start or reset.
- overrun  output  1  sticky; a word was offered (word_valid=1) while in DONE.

Behaviour:
- Reset (synchronous, active-high, highest priority, also mid-load):
  - State goes to IDLE; counters and shift register are cleared.
  - Output values during and after reset: word_ready=0, chain_data=0, chain_enable=0, chain_nreset=1, busy=0, done=0, overrun=0.
  - A reset mid-load abandons the load; chain contents are undefined until the next full load.
- States: IDLE, CLEAR, WAIT_WORD, SHIFT, DONE.
- IDLE: start=1 -> CLEAR; the clear counter loads CLEAR_CYCLES-1. word_valid is ignored.
- CLEAR:
  - chain_nreset=0 on every CLEAR cycle, i.e. exactly CLEAR_CYCLES cycles.
  - When the counter reaches 0 -> WAIT_WORD; bit_count=0.
- WAIT_WORD:
  - word_ready=1.
  - On word_valid=1: latch word_data into the shift register, clear word_bit, go to SHIFT.
  - Otherwise stay in WAIT_WORD indefinitely (no timeout).
- SHIFT:
  - Each cycle: chain_enable=1, chain_data=shreg[0], shreg shifts right (MSB fill 0), bit_count and word_bit increment.
  - If bit_count == CHAIN_LENGTH-1 this cycle -> DONE. Remaining bits of a final partial word are discarded.
  - Else if word_bit == WORD_WIDTH-1 -> WAIT_WORD.
  - Else stay in SHIFT.
- DONE:
  - done=1, chain_enable=0, word_ready=0.
  - word_valid=1 sets overrun.
  - start=1 -> CLEAR; clears done and overrun on the same edge and reloads the chain.
- Throughput: each word costs at least WORD_WIDTH+1 cycles (one WAIT_WORD handshake cycle plus WORD_WIDTH shift cycles).
  - Words needed per load = ceil(CHAIN_LENGTH/WORD_WIDTH).
  - chain_enable is high for exactly CHAIN_LENGTH cycles per load.
- Output timing:
  - chain_enable, chain_nreset, busy, done and word_ready decode from registered state only; no combinational path from any input.
  - chain_data is shreg[0] during SHIFT and 0 otherwise.
- Simultaneous events:
  - start in CLEAR, WAIT_WORD or SHIFT is ignored.
  - start and word_valid together in DONE: restart takes effect, and overrun is cleared rather than set.
- Width rules: bit_count is $clog2(CHAIN_LENGTH+1) bits wide, word_bit is $clog2(WORD_WIDTH) bits wide, and neither counter wraps within a load.

Test Plan (WORD_WIDTH=4, CHAIN_LENGTH=10, CLEAR_CYCLES=2 unless stated):
- Basic load:
  - Stimulus: start, then words 0xA, 0x5, 0x3 offered back-to-back.
  - Required: chain_nreset low exactly 2 cycles; chain_enable high 10 cycles total.
  - chain_data over enable cycles = 0,1,0,1,1,0,1,0,1,1.
  - The two upper bits of 0x3 are never driven. done=1 after the last enable cycle; busy=0.
- Stalled source:
  - Stimulus: hold word_valid low 7 cycles between words.
  - Required: word_ready stays 1, chain_enable stays 0 during the gap, and the serial stream is identical to the basic load.
- Overrun:
  - Stimulus: after done, assert word_valid for 1 cycle.
  - Required: overrun=1 and sticky; a following start clears done and overrun and re-enters CLEAR.
- Mid-load reset:
  - Stimulus: reset during the 2nd SHIFT of word 2.
  - Required: next cycle all outputs at reset values, state IDLE; a subsequent full load completes normally.
- Ignored start:
  - Stimulus: pulse start while in SHIFT.
  - Required: no restart; bit sequence and total of 10 enable cycles unchanged.
- Exact multiple:
  - Stimulus: CHAIN_LENGTH=8, words 0xF, 0x0.
  - Required: stream 1,1,1,1,0,0,0,0; done after 8 enable cycles; no third word_ready.
